// File: rtl/vx_exec_exit_monitor.sv
// Execute-stage exit monitor: detects EBREAK/ECALL on any dispatch slot, captures the
// first event, waits for the pipeline to drain, then flags done. Optional watchdog: VX_EXIT_WATCHDOG_EN.
module vx_exec_exit_monitor #(
   parameter int unsigned NUM_SLOTS    = 4,
   parameter int unsigned NW_WIDTH     = 3,
   parameter int unsigned BR_BITS      = 4,
   parameter int unsigned MONITOR_WID  = 0,
   parameter int unsigned ALL_WARPS    = 0,
   parameter int unsigned DRAIN_CYCLES = 16,
   parameter int unsigned CNT_WIDTH    = 16,
   parameter int unsigned WDOG_CYCLES  = 65536
) (
   input  logic                                                clk,
   input  logic                                                reset,
   input  logic [NUM_SLOTS-1:0]                                slot_valid,
   input  logic [NUM_SLOTS-1:0]                                slot_ready,
   input  logic [NUM_SLOTS*NW_WIDTH-1:0]                       slot_wid,
   input  logic [NUM_SLOTS-1:0]                                slot_is_br,
   input  logic [NUM_SLOTS*BR_BITS-1:0]                        slot_br_op,
   input  logic                                                idle_in,
   input  logic                                                clear,
   output logic                                                sim_ebreak,
   output logic                                                exit_pending,
   output logic                                                exit_done,
   output logic [1:0]                                          exit_cause,
   output logic [((NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1)-1:0] exit_slot,
   output logic [NW_WIDTH-1:0]                                 exit_wid,
   output logic [CNT_WIDTH-1:0]                                event_count
);

   localparam int unsigned SLOT_W = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1;
   localparam int unsigned DCNT_W = (DRAIN_CYCLES > 0) ? $clog2(DRAIN_CYCLES + 1) : 1;
   localparam int unsigned SUM_W  = CNT_WIDTH + 1;
   localparam logic [DCNT_W-1:0]  DRAIN_LOAD = DCNT_W'(DRAIN_CYCLES);
   localparam logic [BR_BITS-1:0] BR_ECALL   = BR_BITS'(4'hA);
   localparam logic [BR_BITS-1:0] BR_EBREAK  = BR_BITS'(4'hB);
   localparam logic [1:0] CAUSE_NONE = 2'b00;
   localparam logic [1:0] CAUSE_EBRK = 2'b01;
   localparam logic [1:0] CAUSE_ECAL = 2'b10;
   localparam logic [1:0] CAUSE_WDOG = 2'b11;

   typedef enum logic [1:0] {ST_RUN, ST_DRAIN, ST_DONE} state_e;

   state_e                state_q, state_d;
   logic [1:0]            exit_cause_q, exit_cause_d;
   logic [SLOT_W-1:0]     exit_slot_q, exit_slot_d;
   logic [NW_WIDTH-1:0]   exit_wid_q, exit_wid_d;
   logic [CNT_WIDTH-1:0]  event_count_q, event_count_d;
   logic [DCNT_W-1:0]     drain_q, drain_d;

   logic [NUM_SLOTS-1:0]  fire_c;
   logic                  any_fire_c;
   logic [SLOT_W-1:0]     first_slot_c;
   logic                  first_ecall_c;
   logic [NW_WIDTH-1:0]   first_wid_c;
   logic [SUM_W-1:0]      fire_cnt_c;
   logic [SUM_W-1:0]      count_sum_c;
   logic                  wdog_hit_c;

   // Qualify each slot, pick the lowest-index firing slot and popcount the fires
   always_comb begin
      fire_c        = '0;
      first_slot_c  = '0;
      first_ecall_c = 1'b0;
      first_wid_c   = '0;
      fire_cnt_c    = '0;
      for (int i = 0; i < NUM_SLOTS; i++) begin
         fire_c[i] = slot_valid[i] & slot_ready[i] & slot_is_br[i]
                   & ((slot_br_op[i*BR_BITS +: BR_BITS] == BR_EBREAK)
                    | (slot_br_op[i*BR_BITS +: BR_BITS] == BR_ECALL))
                   & ((ALL_WARPS != 0) | (slot_wid[i*NW_WIDTH +: NW_WIDTH] == NW_WIDTH'(MONITOR_WID)));
         fire_cnt_c = fire_cnt_c + SUM_W'(fire_c[i]);
      end
      for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
         if (fire_c[i]) begin
            first_slot_c  = SLOT_W'(i);
            first_ecall_c = (slot_br_op[i*BR_BITS +: BR_BITS] == BR_ECALL);
            first_wid_c   = slot_wid[i*NW_WIDTH +: NW_WIDTH];
         end
      end
   end

   assign any_fire_c = |fire_c;

`ifdef VX_EXIT_WATCHDOG_EN
   localparam int unsigned WD_W = (WDOG_CYCLES > 1) ? $clog2(WDOG_CYCLES) : 1;
   logic [WD_W-1:0] wdog_q, wdog_d;
   logic            handshake_c;

   assign handshake_c = |(slot_valid & slot_ready);
   assign wdog_hit_c  = (state_q == ST_RUN) && !any_fire_c && (wdog_q == WD_W'(WDOG_CYCLES - 1));

   always_comb begin
      wdog_d = '0;
      if (state_q == ST_RUN && !handshake_c && !wdog_hit_c) wdog_d = wdog_q + WD_W'(1);
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) wdog_q <= '0;
      else        wdog_q <= wdog_d;
   end
`else
   logic unused_wdog;
   assign unused_wdog = ^32'(WDOG_CYCLES);
   assign wdog_hit_c  = 1'b0;
`endif

   // State register
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state_q <= ST_RUN;
      else        state_q <= state_d;
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         ST_RUN: begin
            if (any_fire_c)      state_d = (DRAIN_CYCLES == 0) ? ST_DONE : ST_DRAIN;
            else if (wdog_hit_c) state_d = ST_DONE;
         end
         ST_DRAIN: if (idle_in && drain_q == DCNT_W'(1)) state_d = ST_DONE;
         ST_DONE:  if (clear) state_d = ST_RUN;
         default:  state_d = ST_RUN;
      endcase
   end

   // Capture, drain counter and saturating event count
   always_comb begin
      exit_cause_d = exit_cause_q;
      exit_slot_d  = exit_slot_q;
      exit_wid_d   = exit_wid_q;
      drain_d      = DRAIN_LOAD;
      count_sum_c  = ((state_q == ST_DONE && clear) ? SUM_W'(0) : SUM_W'(event_count_q)) + fire_cnt_c;
      event_count_d = count_sum_c[CNT_WIDTH] ? '1 : count_sum_c[CNT_WIDTH-1:0];
      unique case (state_q)
         ST_RUN: begin
            if (any_fire_c) begin
               exit_cause_d = first_ecall_c ? CAUSE_ECAL : CAUSE_EBRK;
               exit_slot_d  = first_slot_c;
               exit_wid_d   = first_wid_c;
            end else if (wdog_hit_c) begin
               exit_cause_d = CAUSE_WDOG;
               exit_slot_d  = '0;
               exit_wid_d   = '0;
            end
         end
         ST_DRAIN: if (idle_in) drain_d = drain_q - DCNT_W'(1);
         ST_DONE: begin
            if (clear) begin
               exit_cause_d = CAUSE_NONE;
               exit_slot_d  = '0;
               exit_wid_d   = '0;
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         exit_cause_q  <= CAUSE_NONE;
         exit_slot_q   <= '0;
         exit_wid_q    <= '0;
         event_count_q <= '0;
         drain_q       <= DRAIN_LOAD;
      end else begin
         exit_cause_q  <= exit_cause_d;
         exit_slot_q   <= exit_slot_d;
         exit_wid_q    <= exit_wid_d;
         event_count_q <= event_count_d;
         drain_q       <= drain_d;
      end
   end

   // Output decode
   always_comb begin
      sim_ebreak   = any_fire_c;
      exit_pending = (state_q == ST_DRAIN);
      exit_done    = (state_q == ST_DONE);
   end

   assign exit_cause  = exit_cause_q;
   assign exit_slot   = exit_slot_q;
   assign exit_wid    = exit_wid_q;
   assign event_count = event_count_q;

endmodule

// File: doc/vx_exec_exit_monitor.md
Name: vx_exec_exit_monitor

Overview:
- Parametrised successor to the single-slot simulation ebreak detector in the execute stage.
- Watches all NUM_SLOTS ALU dispatch streams for EBREAK/ECALL on a selectable warp (or all warps).
- Captures the first exit event, then waits for the pipeline to drain before declaring done.
- Provides a legacy same-cycle `sim_ebreak` pulse plus registered exit status for testbench and host harness.

Parameters:
- NUM_SLOTS, 4, number of monitored dispatch slots (matches ISSUE_WIDTH).
- NW_WIDTH, 3, warp-id width.
- BR_BITS, 4, branch op-type width (`INST_BR_BITS`).
- MONITOR_WID, 0, warp id that triggers exit when ALL_WARPS=0.
- ALL_WARPS, 0, 1 = any warp triggers.
- DRAIN_CYCLES, 16, consecutive idle cycles required after detection.
- CNT_WIDTH, 16, event counter width.
- WDOG_CYCLES, 65536, watchdog limit (only used with the optional feature).

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-low reset.
- slot_valid  in  NUM_SLOTS  dispatch valid per slot.
- slot_ready  in  NUM_SLOTS  dispatch ready per slot.
- slot_wid  in  NUM_SLOTS*NW_WIDTH  warp id per slot; slot i occupies bits [i*NW_WIDTH +: NW_WIDTH].
- slot_is_br  in  NUM_SLOTS  op_mod decodes as branch class.
- slot_br_op  in  NUM_SLOTS*BR_BITS  branch op type per slot.
- idle_in  in  1  execute/commit pipeline empty.
- clear  in  1  re-arm request.
- sim_ebreak  out  1  combinational: any qualifying fire this cycle.
- exit_pending  out  1  state == DRAIN.
- exit_done  out  1  state == DONE.
- exit_cause  out  2  00 none, 01 ebreak, 10 ecall, 11 watchdog.
- exit_slot  out  max(1,$clog2(NUM_SLOTS))  slot of the captured event.
- exit_wid  out  NW_WIDTH  warp of the captured event.
- event_count  out  CNT_WIDTH  saturating count of qualifying fires.

Behaviour:
- fire[i] = slot_valid[i] & slot_ready[i] & slot_is_br[i] & (slot_br_op[i] is `INST_BR_EBREAK` or `INST_BR_ECALL`) & (ALL_WARPS | slot_wid[i]==MONITOR_WID).
- sim_ebreak = |fire, zero latency, in every state.
- Reset (reset=0, async): state=RUN, exit_cause=0, exit_slot=0, exit_wid=0, event_count=0, drain counter=DRAIN_CYCLES, exit_pending=0, exit_done=0.
- State RUN, any fire:
  - Capture the lowest-index firing slot: cause (EBREAK→01, ECALL→10), slot, wid.
  - Next state DRAIN, or DONE if DRAIN_CYCLES==0.
  - Captured values are visible one cycle after the fire.
- State DRAIN:
  - Counter decrements each cycle idle_in=1; reloads to DRAIN_CYCLES on idle_in=0.
  - Counter at 1 with idle_in=1 → DONE next cycle.
  - clear is ignored.
- State DONE:
  - Holds capture until clear.
  - clear=1 → RUN next cycle, capture zeroed, event_count zeroed, drain counter reloaded.
- Capture register writes occur only in the RUN→DRAIN/DONE transition. Later fires never overwrite the capture.
- event_count:
  - Adds popcount(fire) each cycle in any state; saturates at all-ones with no wrap.
  - On a cycle with clear in DONE, the result is popcount(fire) of that cycle, not old count + popcount.
  - A fire coinciding with clear is counted but not captured.

Optional Feature:
- Macro: VX_EXIT_WATCHDOG_EN.
- When defined:
  - Watchdog counter increments each RUN cycle with no slot handshake (valid&ready on any slot); it resets to 0 on any handshake or on leaving RUN.
  - On reaching WDOG_CYCLES-1 in RUN with no fire that cycle: capture cause=11, exit_slot=0, exit_wid=0, go directly to DONE.
  - A fire in the same cycle takes priority over the watchdog.
- When undefined: no watchdog logic; cause 11 never produced; WDOG_CYCLES unused.

Test Plan:
- NUM_SLOTS=4, MONITOR_WID=0; slot 2 fires EBREAK wid=0, idle_in=1 → sim_ebreak=1 same cycle; next cycle exit_cause=01, exit_slot=2, exit_pending=1; exit_done=1 exactly 16 cycles later; event_count=1.
- Slots 1 (ECALL) and 3 (EBREAK) fire the same cycle → exit_slot=1, exit_cause=10, event_count=2.
- ALL_WARPS=0, EBREAK on wid=5 → sim_ebreak=0, state stays RUN, count=0. Repeat with ALL_WARPS=1 → capture with exit_wid=5.
- During DRAIN, drop idle_in to 0 at drain count 3, restore → DONE only after 16 further idle cycles. A second fire in DRAIN → count=2, capture unchanged. clear during DRAIN has no effect.
- In DONE, assert clear together with a slot-0 fire → next cycle RUN, exit_cause=00, event_count=1. Async reset asserted mid-DRAIN → all outputs zero immediately.
- With VX_EXIT_WATCHDOG_EN, WDOG_CYCLES=8, no handshakes → exit_done=1, exit_cause=11 after 8 cycles. Without the macro → state stays RUN indefinitely.
